tdm_demux6: RTL and testbench



---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_slot_ctr.sv | 31 +++
 rtl/tdm_demux6.sv | 111 +++++++++++
 tb/tb_tdm_demux6.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM serializer/deserializer pair: frame geometry,
// controller states and the slot-counter width helper.
package tdm_pkg;

  localparam int CH_DEFAULT = 6;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } tdm_state_t;

  // Slot counter width; a 1-bit floor keeps degenerate channel counts legal.
  function automatic int slot_w(input int ch);
    return (ch < 2) ? 1 : $clog2(ch);
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-CH slot counter with clear and load-to-1, shared by both sides of the
// TDM link. Priority: clear, then load, then increment.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int CH = CH_DEFAULT,
  localparam int SW = slot_w(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [SW-1:0] slot
);

  // NOTE: non-blocking (<=) for every flop so all registers update from
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SW'(1);
    end else if (inc) begin
      slot <= (slot == SW'(CH - 1)) ? '0 : slot + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux6.sv
// Receive-side TDM demultiplexer: collects CH framed beats into a shadow
// register and publishes the whole frame on dout with a one-cycle strobe.
module tdm_demux6
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CH    = CH_DEFAULT,
  parameter int ERRW  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    din,
  input  logic                din_valid,
  input  logic                din_sof,
  output logic [CH*WIDTH-1:0] dout,
  output logic                dout_valid,
  output logic                busy,
  output logic                frame_err,
  output logic [ERRW-1:0]     err_cnt
);

  localparam int SW = slot_w(CH);

  tdm_state_t                   state, state_nxt;
  logic       [SW-1:0]          slot;
  logic       [CH-1:0][WIDTH-1:0] shadow;
  logic       [CH*WIDTH-1:0]    frame_merged;
  logic       [SW-1:0]          wr_idx;
  logic                         shadow_we;
  logic                         slot_clr, slot_load1, slot_inc;
  logic                         frame_done, err_evt;

  tdm_slot_ctr #(.CH(CH)) u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (slot_clr),
    .load1 (slot_load1),
    .inc   (slot_inc),
    .slot  (slot)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    slot_clr   = 1'b0;
    slot_load1 = 1'b0;
    slot_inc   = 1'b0;
    frame_done = 1'b0;
    err_evt    = 1'b0;
    if (din_valid) begin
      unique case (state)
        IDLE: begin
          if (din_sof) begin
            slot_load1 = 1'b1;
            state_nxt  = COLLECT;
          end else begin
            err_evt = 1'b1;
          end
        end
        COLLECT: begin
          if (din_sof) begin
            // Premature sof restarts the frame on this beat.
            err_evt    = 1'b1;
            slot_load1 = 1'b1;
          end else if (slot == SW'(CH - 1)) begin
            frame_done = 1'b1;
            slot_clr   = 1'b1;
            state_nxt  = IDLE;
          end else begin
            slot_inc = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign shadow_we    = din_valid && (din_sof || state == COLLECT);
  assign wr_idx       = din_sof ? '0 : slot;
  // The final beat bypasses the shadow so dout updates on the same edge.
  assign frame_merged = {din, shadow[CH-2:0]};
  assign busy         = (state == COLLECT);

  // NOTE: the shadow array is reset because its cleared state is part of the
  // defined reset behaviour, not just for simulation tidiness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shadow <= '0;
    end else begin
      state <= state_nxt;
      if (shadow_we) shadow[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      dout_valid <= frame_done;
      frame_err  <= err_evt;
      if (frame_done) dout <= frame_merged;
      if (err_evt && err_cnt != {ERRW{1'b1}}) err_cnt <= err_cnt + ERRW'(1);
    end
  end

endmodule

// File: tb/tb_tdm_demux6.sv
// Self-checking bench for tdm_demux6: directed frame scenarios plus random
// beats, compared each cycle against a queue-based frame model.
module tb_tdm_demux6;

  localparam int TW  = 4;
  localparam int TCH = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [TW-1:0]     din;
  logic              din_valid, din_sof;
  logic [TCH*TW-1:0] dout, dout_s;
  logic              dout_valid, busy, frame_err;
  logic              dout_valid_s, busy_s, frame_err_s;
  logic [7:0]        err_cnt;
  logic [1:0]        err_cnt_s;

  tdm_demux6 #(.WIDTH(TW), .CH(TCH), .ERRW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_sof(din_sof),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .frame_err(frame_err),
    .err_cnt(err_cnt)
  );

  tdm_demux6 #(.WIDTH(TW), .CH(TCH), .ERRW(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_sof(din_sof),
    .dout(dout_s), .dout_valid(dout_valid_s), .busy(busy_s), .frame_err(frame_err_s),
    .err_cnt(err_cnt_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dv_cycles[$];

  // Reference model: a frame is the list of beats seen since the last sof.
  logic [TW-1:0]     beats[$];
  bit                m_collect;
  logic [TCH*TW-1:0] m_dout;
  bit                m_dv, m_fe;
  int                m_err, m_err_sat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    beats.delete();
    m_collect = 0;
    m_dout    = '0;
    m_dv      = 0;
    m_fe      = 0;
    m_err     = 0;
    m_err_sat = 0;
  endtask

  task automatic model_error();
    m_fe = 1;
    if (m_err < 255) m_err++;
    if (m_err_sat < 3) m_err_sat++;
  endtask

  task automatic model_beat(input bit v, input bit sof, input logic [TW-1:0] d);
    m_dv = 0;
    m_fe = 0;
    if (!v) return;
    if (sof) begin
      if (m_collect) model_error();
      beats.delete();
      beats.push_back(d);
      m_collect = 1;
    end else if (!m_collect) begin
      model_error();
    end else begin
      beats.push_back(d);
      if (beats.size() == TCH) begin
        for (int i = 0; i < TCH; i++) m_dout[i*TW +: TW] = beats[i];
        m_dv      = 1;
        m_collect = 0;
        beats.delete();
      end
    end
  endtask

  task automatic compare_all();
    check("dout",       32'(dout),       32'(m_dout));
    check("dout_valid", 32'(dout_valid), 32'(m_dv));
    check("frame_err",  32'(frame_err),  32'(m_fe));
    check("busy",       32'(busy),       32'(m_collect));
    check("err_cnt",    32'(err_cnt),    32'(m_err));
    check("err_cnt_sat", 32'(err_cnt_s), 32'(m_err_sat));
  endtask

  // Drive one beat, clock it, then compare one step after the edge.
  task automatic step(input bit v, input bit sof, input logic [TW-1:0] d);
    din_valid = v;
    din_sof   = sof;
    din       = v ? d : 'x;
    @(posedge clk);
    cyc++;
    model_beat(v, sof, d);
    #1;
    if (dout_valid) dv_cycles.push_back(cyc);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0);
  endtask

  task automatic frame(input logic [TW-1:0] base, input int gap);
    for (int k = 0; k < TCH; k++) begin
      if (k > 0) idle(gap);
      step(1, k == 0, TW'(base + k));
    end
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    din_valid = 0;
    din_sof   = 0;
    din       = '0;
    rst_n     = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Beat without sof in IDLE: dropped, error counted, dout stays 0.
    step(1, 0, 4'hF);
    idle(1);

    // Contiguous frame then gapped frame, both 0x654321.
    frame(4'h1, 0);
    idle(2);
    frame(4'h1, 3);
    idle(2);

    // Premature sof: A/B discarded, restarted frame completes.
    step(1, 1, 4'hA);
    step(1, 0, 4'hB);
    frame(4'h1, 0);
    idle(1);

    // Back-to-back frames: strobes exactly CH cycles apart.
    dv_cycles.delete();
    frame(4'h3, 0);
    frame(4'h7, 0);
    idle(1);
    if (dv_cycles.size() == 2) check("b2b_spacing", 32'(dv_cycles[1] - dv_cycles[0]), 32'(TCH));
    else check("b2b_pulses", 32'(dv_cycles.size()), 32'd2);

    // Asynchronous reset after slot 3, then a clean frame.
    for (int k = 0; k < 4; k++) step(1, k == 0, TW'(k + 9));
    async_reset();
    idle(1);
    frame(4'h1, 1);
    idle(1);

    // Five errors: narrow counter saturates at 3.
    for (int i = 0; i < 5; i++) step(1, 0, TW'(i));
    idle(1);

    // Random traffic with gaps, premature sofs and stray beats.
    for (int i = 0; i < 1500; i++) begin
      bit v, sof;
      v   = ($urandom % 10) < 7;
      sof = m_collect ? (($urandom % 16) == 0) : (($urandom % 8) != 0);
      step(v, sof, TW'($urandom));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
